// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM arbiter slice.
//   NREQ_MAX   : largest supported requester count
//   idx_w(n)   : bits needed to index n entries (never less than 1)
//   req_type_e : request type carried on we_i (RD = 0, WR = 1)
package ram_arb_pkg;

  localparam int unsigned NREQ_MAX = 8;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } req_type_e;

  function automatic int unsigned idx_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter with its own registered priority pointer.
// The search starts at the pointer and wraps modulo N; the first eligible
// index wins. After a grant to k the pointer moves to (k+1) mod N, with no
// grant it holds. The pointer resets to 0.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   eligible_i    : per-index request eligibility
//   gnt_o         : one-hot grant, combinational in the request cycle
module rr_arb
  import ram_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] eligible_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned W = idx_w(N);

  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx;
  logic         found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = W'((32'(ptr_q) + i) % N);
      if (!found && eligible_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = W'((32'(idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_arb.sv
// Shares one simple dual-port RAM (one write port, one read port, 1-cycle
// registered read data) between NREQ requesters. Independent round-robin
// arbiters grant the write and the read port every cycle.
// Optional feature: define RAM_ARB_FWD_EN to forward write data to a read
// granted in the same cycle to the same address (new-data semantics).
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   req_i, we_i              : per-requester valid and type (1 = write)
//   addr_i, data_i           : packed per-requester address / write data
//   gnt_o                    : combinational grants (write | read)
//   rvalid_o, rdata_o        : one-hot read strobe, shared read data
//   ram_addrw_o, ram_data_o,
//   ram_we_o, ram_ena_o      : RAM write port
//   ram_addrr_o, ram_data_i  : RAM read port
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned DSIZE = 32,
  parameter int unsigned ASIZE = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ-1:0]       we_i,
  input  logic [NREQ*ASIZE-1:0] addr_i,
  input  logic [NREQ*DSIZE-1:0] data_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       rvalid_o,
  output logic [DSIZE-1:0]      rdata_o,
  output logic [ASIZE-1:0]      ram_addrw_o,
  output logic [DSIZE-1:0]      ram_data_o,
  output logic                  ram_we_o,
  output logic                  ram_ena_o,
  output logic [ASIZE-1:0]      ram_addrr_o,
  input  logic [DSIZE-1:0]      ram_data_i
);

  logic [NREQ-1:0] elig_w, elig_r;
  logic [NREQ-1:0] gnt_w, gnt_r;
  logic [NREQ-1:0] rvalid_q;

  // Eligibility is masked by reset so nothing is granted while in reset.
  for (genvar k = 0; k < NREQ; k++) begin : g_elig
    assign elig_w[k] = rst_ni & req_i[k] & (req_type_e'(we_i[k]) == WR);
    assign elig_r[k] = rst_ni & req_i[k] & (req_type_e'(we_i[k]) == RD);
  end

  rr_arb #(
    .N (NREQ)
  ) u_arb_w (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .eligible_i (elig_w),
    .gnt_o      (gnt_w)
  );

  rr_arb #(
    .N (NREQ)
  ) u_arb_r (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .eligible_i (elig_r),
    .gnt_o      (gnt_r)
  );

  assign gnt_o = gnt_w | gnt_r;

  // Grants are one-hot, so OR-ing the selected fields is a plain mux.
  always_comb begin
    ram_addrw_o = '0;
    ram_data_o  = '0;
    ram_addrr_o = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (gnt_w[k]) begin
        ram_addrw_o = ram_addrw_o | addr_i[k*ASIZE +: ASIZE];
        ram_data_o  = ram_data_o | data_i[k*DSIZE +: DSIZE];
      end
      if (gnt_r[k]) begin
        ram_addrr_o = ram_addrr_o | addr_i[k*ASIZE +: ASIZE];
      end
    end
  end

  assign ram_we_o  = |gnt_w;
  assign ram_ena_o = |gnt_w;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt_r;
    end
  end

  assign rvalid_o = rvalid_q;

`ifdef RAM_ARB_FWD_EN
  logic             fwd_q;
  logic [DSIZE-1:0] fwd_data_q;

  // Read port address is 0 when idle, so a real read grant is required too.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= ram_we_o & (|gnt_r) & (ram_addrw_o == ram_addrr_o);
      fwd_data_q <= ram_data_o;
    end
  end

  assign rdata_o = fwd_q ? fwd_data_q : ram_data_i;
`else
  assign rdata_o = ram_data_i;
`endif

endmodule

// File: tb/tb_ram_arb.sv
// Self-checking bench for ram_arb (NREQ = 4). A behavioural RAM sits on the
// RAM ports; a reference model tracks the round-robin pointers, the expected
// memory contents and the expected read return.
module tb_ram_arb;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DSIZE = 32;
  localparam int unsigned ASIZE = 6;
  localparam int unsigned DEPTH = 1 << ASIZE;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [NREQ-1:0]       req_i = '0;
  logic [NREQ-1:0]       we_i = '0;
  logic [NREQ*ASIZE-1:0] addr_i = '0;
  logic [NREQ*DSIZE-1:0] data_i = '0;
  logic [NREQ-1:0]       gnt_o, rvalid_o;
  logic [DSIZE-1:0]      rdata_o, ram_data_o, ram_data_i;
  logic [ASIZE-1:0]      ram_addrw_o, ram_addrr_o;
  logic                  ram_we_o, ram_ena_o;

  int checks = 0;
  int errors = 0;

  ram_arb #(
    .NREQ  (NREQ),
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .ram_addrw_o (ram_addrw_o),
    .ram_data_o  (ram_data_o),
    .ram_we_o    (ram_we_o),
    .ram_ena_o   (ram_ena_o),
    .ram_addrr_o (ram_addrr_o),
    .ram_data_i  (ram_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural block RAM: write at the edge, registered read of old data.
  logic [DSIZE-1:0] mem [DEPTH] = '{default: '0};
  always @(posedge clk_i) begin
    if (ram_we_o && ram_ena_o) mem[ram_addrw_o] <= ram_data_o;
    ram_data_i <= mem[ram_addrr_o];
  end

  // Reference model state.
  int               m_ptr_w, m_ptr_r;
  logic [DSIZE-1:0] ref_mem [DEPTH] = '{default: '0};
  logic [NREQ-1:0]  m_rv;
  logic [DSIZE-1:0] m_rdata;

  // Per-cycle expectations and observations, filled by tick().
  int               e_kw, e_kr;
  logic [NREQ-1:0]  e_gnt, e_rv;
  logic [DSIZE-1:0] e_rdata, e_dataw;
  logic [ASIZE-1:0] e_addrw, e_addrr;
  logic [NREQ-1:0]  o_gnt, o_rv;
  logic [DSIZE-1:0] o_rdata, o_dataw;
  logic [ASIZE-1:0] o_addrw, o_addrr;
  logic             o_we, o_ena;

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] elig);
    for (int i = 0; i < int'(NREQ); i++) begin
      if (elig[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int k, input logic r, input logic w,
                         input logic [ASIZE-1:0] a, input logic [DSIZE-1:0] d);
    req_i[k]                 = r;
    we_i[k]                  = w;
    addr_i[k*ASIZE +: ASIZE] = a;
    data_i[k*DSIZE +: DSIZE] = d;
  endtask

  task automatic model_reset();
    m_ptr_w = 0;
    m_ptr_r = 0;
    m_rv    = '0;
    m_rdata = '0;
  endtask

  // One clock cycle: sample at the falling edge, advance model at the rising
  // edge, return 1 time unit after it so stimulus can be changed.
  task automatic tick();
    @(negedge clk_i);
    e_kw    = rr_pick(m_ptr_w, req_i & we_i);
    e_kr    = rr_pick(m_ptr_r, req_i & ~we_i);
    e_gnt   = '0;
    e_addrw = '0;
    e_dataw = '0;
    e_addrr = '0;
    if (e_kw >= 0) begin
      e_gnt[e_kw] = 1'b1;
      e_addrw     = addr_i[e_kw*ASIZE +: ASIZE];
      e_dataw     = data_i[e_kw*DSIZE +: DSIZE];
    end
    if (e_kr >= 0) begin
      e_gnt[e_kr] = 1'b1;
      e_addrr     = addr_i[e_kr*ASIZE +: ASIZE];
    end
    e_rv    = m_rv;
    e_rdata = m_rdata;
    o_gnt   = gnt_o;
    o_rv    = rvalid_o;
    o_rdata = rdata_o;
    o_we    = ram_we_o;
    o_ena   = ram_ena_o;
    o_addrw = ram_addrw_o;
    o_dataw = ram_data_o;
    o_addrr = ram_addrr_o;
    @(posedge clk_i);
    m_rv = '0;
    if (e_kr >= 0) begin
      m_rv[e_kr] = 1'b1;
      m_rdata    = ref_mem[e_addrr];
`ifdef RAM_ARB_FWD_EN
      if (e_kw >= 0 && e_addrw == e_addrr) m_rdata = e_dataw;
`endif
      m_ptr_r = (e_kr + 1) % NREQ;
    end
    if (e_kw >= 0) begin
      ref_mem[e_addrw] = e_dataw;
      m_ptr_w          = (e_kw + 1) % NREQ;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < int'(NREQ); k++) set_req(k, 1'b1, k[0], ASIZE'(k + 1), 32'hA5A5_0000);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (gnt_o !== '0 || rvalid_o !== '0) begin
      errors++;
      $display("FAIL reset_gnt_rv: gnt=%b rvalid=%b required 0/0", gnt_o, rvalid_o);
    end
    checks++;
    if ({ram_we_o, ram_ena_o, ram_addrw_o, ram_data_o, ram_addrr_o} !== '0) begin
      errors++;
      $display("FAIL reset_ram: we=%b ena=%b aw=%h dw=%h ar=%h required all 0",
               ram_we_o, ram_ena_o, ram_addrw_o, ram_data_o, ram_addrr_o);
    end
    req_i  = '0;
    rst_ni = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_write_then_read();
    set_req(0, 1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF);
    tick();
    checks++;
    if (o_gnt !== 4'b0001 || o_we !== 1'b1 || o_ena !== 1'b1 || o_addrw !== 6'd5
        || o_dataw !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_grant: gnt=%b we=%b ena=%b aw=%h dw=%h required 0001/1/1/05/deadbeef",
               o_gnt, o_we, o_ena, o_addrw, o_dataw);
    end
    req_i = '0;
    set_req(1, 1'b1, 1'b0, 6'd5, '0);
    tick();
    checks++;
    if (o_gnt !== 4'b0010 || o_addrr !== 6'd5 || o_we !== 1'b0) begin
      errors++;
      $display("FAIL rd_grant: gnt=%b ar=%h we=%b required 0010/05/0", o_gnt, o_addrr, o_we);
    end
    req_i = '0;
    tick();
    checks++;
    if (o_rv !== 4'b0010 || o_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_return: rvalid=%b rdata=%h required 0010/deadbeef", o_rv, o_rdata);
    end
    tick();
    checks++;
    if (o_rv !== '0) begin
      errors++;
      $display("FAIL rd_single_pulse: rvalid=%b required 0000", o_rv);
    end
  endtask

  task automatic test_two_writers();
    int prev = -1;
    int k;
    req_i = '0;
    set_req(0, 1'b1, 1'b1, 6'd16, $urandom);
    set_req(1, 1'b1, 1'b1, 6'd17, $urandom);
    for (int c = 0; c < 8; c++) begin
      tick();
      k = e_kw;
      checks++;
      if (o_gnt !== e_gnt || (prev >= 0 && k == prev)) begin
        errors++;
        $display("FAIL two_wr_alt: gnt=%b required %b (prev winner %0d)", o_gnt, e_gnt, prev);
      end
      prev = k;
      if (k >= 0) data_i[k*DSIZE +: DSIZE] = $urandom;
    end
    req_i = '0;
    tick();
    checks++;
    if (mem[16] !== ref_mem[16] || mem[17] !== ref_mem[17]) begin
      errors++;
      $display("FAIL two_wr_land: mem16=%h mem17=%h required %h %h",
               mem[16], mem[17], ref_mem[16], ref_mem[17]);
    end
  endtask

  task automatic test_four_readers();
    logic [DSIZE-1:0] vals [NREQ];
    int prev = -1;
    int k;
    req_i = '0;
    for (int a = 0; a < int'(NREQ); a++) begin
      vals[a] = $urandom;
      set_req(3, 1'b1, 1'b1, ASIZE'(a), vals[a]);
      tick();
    end
    for (int a = 0; a < int'(NREQ); a++) set_req(a, 1'b1, 1'b0, ASIZE'(a), '0);
    for (int c = 0; c < 6; c++) begin
      if (c == 5) req_i = '0;
      tick();
      k = e_kr;
      checks++;
      if (o_gnt !== e_gnt || (prev >= 0 && k >= 0 && k != (prev + 1) % int'(NREQ))) begin
        errors++;
        $display("FAIL four_rd_order: gnt=%b required %b (prev winner %0d)", o_gnt, e_gnt, prev);
      end
      if (prev >= 0) begin
        checks++;
        if (o_rv !== (4'b0001 << prev) || o_rdata !== vals[prev]) begin
          errors++;
          $display("FAIL four_rd_data: rvalid=%b rdata=%h required %b/%h",
                   o_rv, o_rdata, 4'b0001 << prev, vals[prev]);
        end
      end
      prev = k;
    end
  endtask

  task automatic test_same_addr();
    logic [DSIZE-1:0] exp_first;
`ifdef RAM_ARB_FWD_EN
    exp_first = 32'h22;
`else
    exp_first = 32'h11;
`endif
    req_i = '0;
    set_req(0, 1'b1, 1'b1, 6'd7, 32'h11);
    tick();
    set_req(0, 1'b1, 1'b1, 6'd7, 32'h22);
    set_req(1, 1'b1, 1'b0, 6'd7, '0);
    tick();
    checks++;
    if (o_gnt !== 4'b0011) begin
      errors++;
      $display("FAIL same_addr_gnt: gnt=%b required 0011", o_gnt);
    end
    req_i = '0;
    tick();
    checks++;
    if (o_rv !== 4'b0010 || o_rdata !== exp_first) begin
      errors++;
      $display("FAIL same_addr_data: rvalid=%b rdata=%h required 0010/%h",
               o_rv, o_rdata, exp_first);
    end
    set_req(1, 1'b1, 1'b0, 6'd7, '0);
    tick();
    req_i = '0;
    tick();
    checks++;
    if (o_rv !== 4'b0010 || o_rdata !== 32'h22) begin
      errors++;
      $display("FAIL same_addr_after: rvalid=%b rdata=%h required 0010/00000022", o_rv, o_rdata);
    end
  endtask

  task automatic test_reset_midop();
    req_i = '0;
    set_req(1, 1'b1, 1'b1, 6'd9, 32'h0BAD_F00D);
    set_req(2, 1'b1, 1'b0, 6'd9, '0);
    tick();
    for (int k = 0; k < int'(NREQ); k++) set_req(k, 1'b1, 1'b0, ASIZE'(k), '0);
    rst_ni = 1'b0;
    #2;
    checks++;
    if (rvalid_o !== '0 || gnt_o !== '0) begin
      errors++;
      $display("FAIL midop_reset: rvalid=%b gnt=%b required 0000/0000", rvalid_o, gnt_o);
    end
    rst_ni = 1'b1;
    model_reset();
    tick();
    checks++;
    if (o_rv !== '0 || o_gnt !== 4'b0001) begin
      errors++;
      $display("FAIL midop_rd_restart: rvalid=%b gnt=%b required 0000/0001", o_rv, o_gnt);
    end
    for (int k = 0; k < int'(NREQ); k++) set_req(k, 1'b1, 1'b1, ASIZE'(k + 40), $urandom);
    tick();
    checks++;
    if (o_gnt !== 4'b0001 || mem[9] !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL midop_wr_restart: gnt=%b mem9=%h required 0001/0badf00d", o_gnt, mem[9]);
    end
    req_i = '0;
    tick();
  endtask

  task automatic test_withdraw();
    logic seen1 = 1'b0;
    req_i = '0;
    set_req(2, 1'b1, 1'b0, 6'd2, '0);
    tick();
    req_i = '0;
    set_req(0, 1'b1, 1'b0, 6'd0, '0);
    set_req(1, 1'b1, 1'b0, 6'd1, '0);
    tick();
    checks++;
    if (o_gnt !== 4'b0001) begin
      errors++;
      $display("FAIL withdraw_prio: gnt=%b required 0001", o_gnt);
    end
    req_i[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) req_i = '0;
      tick();
      if (o_gnt[1] || o_rv[1]) seen1 = 1'b1;
    end
    checks++;
    if (seen1 !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_req1: req1 saw grant/rvalid=%b required 0", seen1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < int'(NREQ); k++) begin
      set_req(k, 1'($urandom), 1'($urandom), ASIZE'($urandom_range(0, 7)), $urandom);
    end
    for (int c = 0; c < 400; c++) begin
      tick();
      checks++;
      if (o_gnt !== e_gnt || o_rv !== e_rv || (e_rv != '0 && o_rdata !== e_rdata)) begin
        errors++;
        $display("FAIL rand_arb[%0d]: gnt=%b rv=%b rd=%h required %b/%b/%h",
                 c, o_gnt, o_rv, o_rdata, e_gnt, e_rv, e_rdata);
      end
      checks++;
      if (o_we !== (e_kw >= 0) || o_ena !== (e_kw >= 0) || o_addrw !== e_addrw
          || o_dataw !== e_dataw || o_addrr !== e_addrr) begin
        errors++;
        $display("FAIL rand_ram[%0d]: we=%b ena=%b aw=%h dw=%h ar=%h required %b/%b/%h/%h/%h",
                 c, o_we, o_ena, o_addrw, o_dataw, o_addrr, e_kw >= 0, e_kw >= 0,
                 e_addrw, e_dataw, e_addrr);
      end
      // Granted or idle requesters pick a fresh request; others hold theirs.
      for (int k = 0; k < int'(NREQ); k++) begin
        if (o_gnt[k] || !req_i[k]) begin
          set_req(k, 1'($urandom), 1'($urandom), ASIZE'($urandom_range(0, 7)), $urandom);
        end
      end
    end
    req_i = '0;
    tick();
    checks++;
    if (o_rv !== e_rv || (e_rv != '0 && o_rdata !== e_rdata)) begin
      errors++;
      $display("FAIL rand_drain: rv=%b rd=%h required %b/%h", o_rv, o_rdata, e_rv, e_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_write_then_read();
    test_two_writers();
    test_four_readers();
    test_same_addr();
    test_reset_midop();
    test_withdraw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
